sensor_image_crop_scale: RTL and testbench

SENSOR_IMAGE_CROP_SCALE -- requirements
Module: sensor_image_crop_scale

---
 rtl/sensor_zoom_pkg.sv | 26 ++
 rtl/image_pos_counter.sv | 54 +++++
 rtl/sensor_image_crop_scale.sv | 146 ++++++++++++++
 tb/tb_sensor_image_crop_scale.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_zoom_pkg.sv
// Shared types and constants for the sensor crop/decimate path:
// frame FSM states, decimation encodings and the frame counter width.
package sensor_zoom_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_ARMED    = 2'd1,
        ST_ACTIVE   = 2'd2
    } zoom_state_t;

    localparam logic [1:0] DEC_X1 = 2'd0;
    localparam logic [1:0] DEC_X2 = 2'd1;
    localparam logic [1:0] DEC_X4 = 2'd2;

    localparam int FRAME_CNT_W = 16;

    // Offset bits that must be zero for a pixel/line to survive decimation.
    function automatic logic [1:0] dec_mask(input logic [1:0] dec_log2);
        case (dec_log2)
            DEC_X2:  return 2'b01;
            DEC_X4:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/image_pos_counter.sv
// Saturating pixel/line position counters with href edge detection; a line
// only counts once its href rising edge has been seen inside the active frame.
module image_pos_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             href,
    input  logic             active,
    output logic [CNT_W-1:0] xpos,
    output logic [CNT_W-1:0] ypos,
    output logic             line_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             href_d_reg;
    logic             in_line_reg;
    logic [CNT_W-1:0] xpos_reg;
    logic [CNT_W-1:0] ypos_reg;
    logic             href_rise;
    logic             href_fall;

    assign href_rise  = href & ~href_d_reg;
    assign href_fall  = ~href & href_d_reg;
    // A line straddling the frame start never had its rising edge in ACTIVE.
    assign line_valid = active & href & (in_line_reg | href_rise);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_d_reg  <= 1'b0;
            in_line_reg <= 1'b0;
            xpos_reg    <= '0;
            ypos_reg    <= '0;
        end else begin
            href_d_reg  <= href;
            in_line_reg <= line_valid;

            if (!href)
                xpos_reg <= '0;
            else if (xpos_reg != CNT_MAX)
                xpos_reg <= xpos_reg + 1'b1;

            if (!active)
                ypos_reg <= '0;
            else if (href_fall && in_line_reg && ypos_reg != CNT_MAX)
                ypos_reg <= ypos_reg + 1'b1;
        end
    end

    assign xpos = xpos_reg;
    assign ypos = ypos_reg;

endmodule

// File: rtl/sensor_image_crop_scale.sv
// Crops a window out of a DVP-style sensor stream and decimates it by 1/2/4
// per axis; config is shadowed at each frame start and validated there.
module sensor_image_crop_scale
    import sensor_zoom_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int IMAGE_HSIZE_SOURCE = 1280,
    parameter int IMAGE_VSIZE_SOURCE = 1024,
    parameter int CNT_W              = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   image_in_vsync,
    input  logic                   image_in_href,
    input  logic [DATA_WIDTH-1:0]  image_in_data,
    input  logic [CNT_W-1:0]       cfg_x_start,
    input  logic [CNT_W-1:0]       cfg_y_start,
    input  logic [CNT_W-1:0]       cfg_width,
    input  logic [CNT_W-1:0]       cfg_height,
    input  logic [1:0]             cfg_hdec_log2,
    input  logic [1:0]             cfg_vdec_log2,
    output logic                   image_out_vsync,
    output logic                   image_out_href,
    output logic [DATA_WIDTH-1:0]  image_out_data,
    output logic                   cfg_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W:0] HSIZE = (CNT_W+1)'(IMAGE_HSIZE_SOURCE);
    localparam logic [CNT_W:0] VSIZE = (CNT_W+1)'(IMAGE_VSIZE_SOURCE);

    zoom_state_t             state_reg;
    logic [CNT_W-1:0]        sh_x_start_reg;
    logic [CNT_W-1:0]        sh_y_start_reg;
    logic [CNT_W:0]          sh_x_end_reg;
    logic [CNT_W:0]          sh_y_end_reg;
    logic [1:0]              sh_hmask_reg;
    logic [1:0]              sh_vmask_reg;
    logic                    cfg_err_reg;
    logic [FRAME_CNT_W-1:0]  frame_cnt_reg;
    logic                    out_vsync_reg;
    logic                    out_href_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg;

    logic [CNT_W-1:0] xpos;
    logic [CNT_W-1:0] ypos;
    logic             line_valid;
    logic             active;

    assign active = (state_reg == ST_ACTIVE);

    image_pos_counter #(.CNT_W(CNT_W)) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .href       (image_in_href),
        .active     (active),
        .xpos       (xpos),
        .ypos       (ypos),
        .line_valid (line_valid)
    );

    // Window ends carry one extra bit so start+size can never wrap.
    logic [CNT_W:0] x_end_cfg;
    logic [CNT_W:0] y_end_cfg;
    logic           cfg_legal;

    assign x_end_cfg = {1'b0, cfg_x_start} + {1'b0, cfg_width};
    assign y_end_cfg = {1'b0, cfg_y_start} + {1'b0, cfg_height};
    assign cfg_legal = (cfg_width != '0) && (cfg_height != '0) &&
                       (x_end_cfg <= HSIZE) && (y_end_cfg <= VSIZE) &&
                       (cfg_hdec_log2 != 2'd3) && (cfg_vdec_log2 != 2'd3);

    logic [1:0] x_off;
    logic [1:0] y_off;
    logic       in_x;
    logic       in_y;
    logic       forward;

    assign x_off   = xpos[1:0] - sh_x_start_reg[1:0];
    assign y_off   = ypos[1:0] - sh_y_start_reg[1:0];
    assign in_x    = (xpos >= sh_x_start_reg) && ({1'b0, xpos} < sh_x_end_reg);
    assign in_y    = (ypos >= sh_y_start_reg) && ({1'b0, ypos} < sh_y_end_reg);
    assign forward = line_valid && !cfg_err_reg && in_x && in_y &&
                     ((x_off & sh_hmask_reg) == 2'b00) &&
                     ((y_off & sh_vmask_reg) == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_WAIT_LOW;
            sh_x_start_reg <= '0;
            sh_y_start_reg <= '0;
            sh_x_end_reg   <= '0;
            sh_y_end_reg   <= '0;
            sh_hmask_reg   <= '0;
            sh_vmask_reg   <= '0;
            cfg_err_reg    <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                ST_WAIT_LOW: begin
                    if (!image_in_vsync)
                        state_reg <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (image_in_vsync) begin
                        state_reg      <= ST_ACTIVE;
                        sh_x_start_reg <= cfg_x_start;
                        sh_y_start_reg <= cfg_y_start;
                        sh_x_end_reg   <= x_end_cfg;
                        sh_y_end_reg   <= y_end_cfg;
                        sh_hmask_reg   <= dec_mask(cfg_hdec_log2);
                        sh_vmask_reg   <= dec_mask(cfg_vdec_log2);
                        cfg_err_reg    <= ~cfg_legal;
                    end
                end
                ST_ACTIVE: begin
                    if (!image_in_vsync) begin
                        state_reg <= ST_ARMED;
                        if (!cfg_err_reg)
                            frame_cnt_reg <= frame_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_WAIT_LOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vsync_reg <= 1'b0;
            out_href_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_vsync_reg <= image_in_vsync;
            out_href_reg  <= forward;
            out_data_reg  <= forward ? image_in_data : '0;
        end
    end

    assign image_out_vsync = out_vsync_reg;
    assign image_out_href  = out_href_reg;
    assign image_out_data  = out_data_reg;
    assign cfg_err         = cfg_err_reg;
    assign frame_cnt       = frame_cnt_reg;

endmodule

// File: tb/tb_sensor_image_crop_scale.sv
// Randomized frame stimulus with a scoreboard: each frame's expected pixels are
// derived from the window/decimation rules and checked by an independent monitor.
`timescale 1ns/1ps
module tb_sensor_image_crop_scale;

    localparam int DW = 8;
    localparam int H  = 16;
    localparam int V  = 8;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vsync = 1'b0;
    logic          in_href = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] cfg_x_start = '0;
    logic [CW-1:0] cfg_y_start = '0;
    logic [CW-1:0] cfg_width = '0;
    logic [CW-1:0] cfg_height = '0;
    logic [1:0]    cfg_hdec_log2 = '0;
    logic [1:0]    cfg_vdec_log2 = '0;
    logic          out_vsync;
    logic          out_href;
    logic [DW-1:0] out_data;
    logic          cfg_err;
    logic [15:0]   frame_cnt;

    int            total = 0;
    int            bad = 0;
    int            frame_model = 0;
    int            frame_no = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] img[V][H];

    always #5 clk = ~clk;

    sensor_image_crop_scale #(
        .DATA_WIDTH(DW), .IMAGE_HSIZE_SOURCE(H), .IMAGE_VSIZE_SOURCE(V), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .image_in_vsync(in_vsync), .image_in_href(in_href), .image_in_data(in_data),
        .cfg_x_start(cfg_x_start), .cfg_y_start(cfg_y_start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_hdec_log2(cfg_hdec_log2), .cfg_vdec_log2(cfg_vdec_log2),
        .image_out_vsync(out_vsync), .image_out_href(out_href), .image_out_data(out_data),
        .cfg_err(cfg_err), .frame_cnt(frame_cnt)
    );

    // Monitor: independent of stimulus, consumes the expected-pixel queue.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            total++;
            if (!rst_n) begin
                if (out_vsync !== 1'b0 || out_href !== 1'b0 || out_data !== '0 ||
                    cfg_err !== 1'b0 || frame_cnt !== 16'd0) begin
                    bad++;
                    $display("FAIL reset_outputs: vsync=%b href=%b data=%h err=%b cnt=%0d, required all 0",
                             out_vsync, out_href, out_data, cfg_err, frame_cnt);
                end
            end else begin
                if (out_vsync !== in_vsync) begin
                    bad++;
                    $display("FAIL vsync_follow: got %b required %b", out_vsync, in_vsync);
                end
                if (out_href === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_pixel: data=%h forwarded with none expected", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            bad++;
                            $display("FAIL pixel_data: got %h required %h", out_data, e);
                        end
                    end
                end else if (out_href !== 1'b0 || out_data !== '0) begin
                    total++;
                    bad++;
                    $display("FAIL idle_output: href=%b data=%h, required 0/00", out_href, out_data);
                end
            end
        end
    end

    function automatic bit window_legal(input int xs, ys, w, h, hd, vd);
        return (w != 0) && (h != 0) && (xs + w <= H) && (ys + h <= V) && (hd < 3) && (vd < 3);
    endfunction

    task automatic check_val(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic run_frame(input int xs, ys, w, h, hd, vd, input bit straddle, input int new_xs);
        bit legal;
        int npix;
        npix = 0;
        @(negedge clk);
        in_vsync = 1'b0; in_href = 1'b0; in_data = '0;
        cfg_x_start = CW'(xs); cfg_y_start = CW'(ys);
        cfg_width = CW'(w);    cfg_height = CW'(h);
        cfg_hdec_log2 = 2'(hd); cfg_vdec_log2 = 2'(vd);
        repeat (3) @(negedge clk);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                img[y][x] = DW'($urandom);
        legal = window_legal(xs, ys, w, h, hd, vd);
        if (legal)
            for (int y = ys; y < ys + h; y++)
                for (int x = xs; x < xs + w; x++)
                    if ((x - xs) % (1 << hd) == 0 && (y - ys) % (1 << vd) == 0) begin
                        exp_q.push_back(img[y][x]);
                        npix++;
                    end
        $display("frame %0d: win=(%0d,%0d,%0d,%0d) dec=%0d/%0d legal=%0d straddle=%0d pixels=%0d",
                 frame_no, xs, ys, w, h, hd, vd, legal, straddle, npix);
        frame_no++;
        if (straddle) begin
            in_href = 1'b1;
            repeat (2) begin in_data = DW'($urandom); @(negedge clk); end
            in_vsync = 1'b1;
            repeat (3) begin in_data = DW'($urandom); @(negedge clk); end
            in_href = 1'b0; in_data = '0;
        end else begin
            in_vsync = 1'b1;
        end
        repeat (3) @(negedge clk);
        check_val("cfg_err_frame_start", int'(cfg_err), int'(!legal));
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                in_href = 1'b1; in_data = img[y][x];
                @(negedge clk);
                if (new_xs >= 0 && y == 0 && x == 0) cfg_x_start = CW'(new_xs);
            end
            in_href = 1'b0; in_data = '0;
            repeat (3) @(negedge clk);
        end
        in_vsync = 1'b0;
        if (legal) frame_model++;
        repeat (3) @(negedge clk);
        check_val("frame_cnt", int'(frame_cnt), frame_model & 16'hFFFF);
        check_val("frame_pixels_left", exp_q.size(), 0);
        check_val("cfg_err_hold", int'(cfg_err), int'(!legal));
    endtask

    task automatic reset_mid_frame();
        @(negedge clk);
        in_vsync = 1'b0; in_href = 1'b0;
        cfg_x_start = '0; cfg_y_start = '0; cfg_width = CW'(H); cfg_height = CW'(V);
        cfg_hdec_log2 = 2'd0; cfg_vdec_log2 = 2'd0;
        repeat (3) @(negedge clk);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                img[y][x] = DW'($urandom);
                exp_q.push_back(img[y][x]);
            end
        $display("frame %0d: full frame with reset asserted mid-line", frame_no);
        frame_no++;
        in_vsync = 1'b1;
        repeat (3) @(negedge clk);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (y == 2 && x == 8) begin
                    rst_n = 1'b0;
                    exp_q.delete();
                    frame_model = 0;
                end
                if (y == 2 && x == 12) rst_n = 1'b1;
                in_href = 1'b1; in_data = img[y][x];
                @(negedge clk);
            end
            in_href = 1'b0; in_data = '0;
            repeat (3) @(negedge clk);
        end
        in_vsync = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_frame_cnt", int'(frame_cnt), 0);
        check_val("reset_cfg_err", int'(cfg_err), 0);
        check_val("reset_pixels_left", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, h, xs, ys;
        repeat (3) @(negedge clk);
        check_val("reset_frame_cnt_initial", int'(frame_cnt), 0);
        rst_n = 1'b1;
        run_frame(2, 1, 8, 4, 0, 0, 1'b0, -1);
        run_frame(2, 1, 8, 4, 1, 1, 1'b0, -1);
        run_frame(2, 1, 8, 4, 0, 0, 1'b0, 4);
        run_frame(4, 1, 8, 4, 0, 0, 1'b0, -1);
        run_frame(10, 0, 8, 4, 0, 0, 1'b0, -1);
        run_frame(0, 0, 16, 8, 2, 1, 1'b0, -1);
        run_frame(1, 1, 6, 3, 3, 0, 1'b0, -1);
        run_frame(0, 2, 5, 0, 0, 0, 1'b0, -1);
        run_frame(3, 2, 7, 5, 1, 2, 1'b1, -1);
        reset_mid_frame();
        run_frame(2, 1, 8, 4, 0, 0, 1'b0, -1);
        for (int i = 0; i < 6; i++) begin
            w  = $urandom_range(1, H);
            h  = $urandom_range(1, V);
            xs = $urandom_range(0, H - w);
            ys = $urandom_range(0, V - h);
            run_frame(xs, ys, w, h, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
